// File: rtl/aes_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_key_schedule
//   AES-128 key expansion engine. A cipher key is accepted on a key_valid /
//   key_ready handshake. One round key is then produced per clock and
//   written into an internal key store. The cipher round datapath reads the
//   store through a registered read port.
//
// Ports
//   clk         clock, all state updates on posedge
//   reset       synchronous, active-high
//   key_valid   key_in holds a new cipher key
//   key_in      128-bit cipher key, [127:96]=w0 ... [31:0]=w3
//   key_ready   a key can be accepted (IDLE or DONE)
//   rk_addr     round-key index, 0..NR
//   rk_data     round key[rk_addr], one-cycle read latency
//   busy        expansion in progress
//   sched_done  all NR+1 round keys are valid in the store
//
// Also contains sub_byte, the shared 32-bit S-box word substitution.
// ---------------------------------------------------------------------------

// sub_byte: applies the AES S-box to each byte of a 32-bit word.
//   plain  word to substitute
//   subst  substituted word
module sub_byte (
  input  logic [31:0] plain,
  output logic [31:0] subst
);

  // Forward S-box packed MSB-first, so entry 0 sits in bits [2047:2040].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b lives at bit offset (255-b)*8, and 255-b is just ~b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  always_comb begin
    subst = {sbox(plain[31:24]), sbox(plain[23:16]),
             sbox(plain[15:8]),  sbox(plain[7:0])};
  end

endmodule

module aes_key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic         busy,
  output logic         sched_done
);

  localparam logic [3:0] LAST = 4'(NR);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t       state, state_next;
  logic [127:0] store [0:NR];
  logic [127:0] cur;
  logic [127:0] next_key;
  logic [3:0]   rnd;
  logic [7:0]   rcon;
  logic [31:0]  rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;
  logic         accept;

  // One round of the key expansion, computed from the previous round key.
  assign rot = {cur[23:0], cur[31:24]};

  sub_byte u_sub (
    .plain (rot),
    .subst (sub)
  );

  always_comb begin
    t        = sub ^ {rcon, 24'h0};
    n0       = cur[127:96] ^ t;
    n1       = cur[95:64]  ^ n0;
    n2       = cur[63:32]  ^ n1;
    n3       = cur[31:0]   ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Outputs are decoded from the state register alone, so key_ready, busy
  // and sched_done never depend combinationally on the key path.
  always_comb begin
    state_next = state;
    key_ready  = 1'b0;
    busy       = 1'b0;
    sched_done = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          accept     = 1'b1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        busy = 1'b1;
        if (rnd == LAST) state_next = DONE;
      end
      DONE: begin
        key_ready  = 1'b1;
        sched_done = 1'b1;
        if (key_valid) begin
          accept     = 1'b1;
          state_next = EXPAND;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The key store is never cleared; sched_done alone says whether it holds
  // a complete schedule.
  always_ff @(posedge clk) begin
    if (reset) begin
      rnd     <= 4'd0;
      rcon    <= 8'h01;
      rk_data <= '0;
    end else begin
      if (accept) begin
        store[0] <= key_in;
        cur      <= key_in;
        rnd      <= 4'd1;
        rcon     <= 8'h01;
      end else if (busy) begin
        store[rnd] <= next_key;
        cur        <= next_key;
        rnd        <= rnd + 4'd1;
        rcon       <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      rk_data <= (rk_addr <= LAST) ? store[rk_addr] : '0;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_aes_key_schedule
//   Self-checking bench for aes_key_schedule (NR=10). The reference model
//   builds the S-box from GF(2^8) inversion plus the affine transform and
//   expands keys word by word with the textbook recurrence.
// ---------------------------------------------------------------------------
module tb_aes_key_schedule;

  localparam int NR = 10;
  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         busy;
  logic         sched_done;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [0:10];

  aes_key_schedule #(.NR(NR)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_in     (key_in),
    .key_ready  (key_ready),
    .rk_addr    (rk_addr),
    .rk_data    (rk_data),
    .busy       (busy),
    .sched_done (sched_done)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  task automatic buildSbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] xb  = 8'(x);
      for (int y = 1; y < 256; y++)
        if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic computeModel(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_m[temp[31:24]], sbox_m[temp[23:16]],
                sbox_m[temp[15:8]],  sbox_m[temp[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= 10; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Presents a key for exactly one posedge; returns at the negedge after it.
  task automatic applyStimulus(input logic [127:0] key);
    @(negedge clk);
    key_in    = key;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Counts posedges after the handshake until sched_done is seen.
  task automatic waitDone(output int n);
    n = 0;
    while (!sched_done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic readKey(input logic [3:0] a, output logic [127:0] d);
    @(negedge clk);
    rk_addr = a;
    @(negedge clk);
    d = rk_data;
  endtask

  task automatic checkSchedule(input string tag);
    logic [127:0] d;
    for (int r = 0; r <= NR; r++) begin
      readKey(4'(r), d);
      checkOutput($sformatf("%s_rk%0d", tag, r), d, exp_rk[r]);
    end
  endtask

  initial begin
    int           n;
    logic [127:0] d, ka, kb, a10;

    reset     = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    rk_addr   = 4'd0;
    buildSbox();
    repeat (3) @(negedge clk);
    checkOutput("rst_key_ready",  128'(key_ready),  128'd1);
    checkOutput("rst_busy",       128'(busy),       128'd0);
    checkOutput("rst_sched_done", 128'(sched_done), 128'd0);
    checkOutput("rst_rk_data",    rk_data,          128'd0);
    reset = 1'b0;

    // FIPS-197 key
    computeModel(FIPS_KEY);
    applyStimulus(FIPS_KEY);
    checkOutput("fips_busy", 128'(busy), 128'd1);
    waitDone(n);
    checkOutput("fips_latency", 128'(n), 128'd10);
    readKey(4'd1, d);
    checkOutput("fips_rk1_const", d, FIPS_RK1);
    readKey(4'd10, d);
    checkOutput("fips_rk10_const", d, FIPS_RK10);
    checkSchedule("fips");
    for (int a = 11; a < 16; a++) begin
      readKey(4'(a), d);
      checkOutput($sformatf("oob_addr%0d", a), d, 128'd0);
    end

    // Reset in the middle of an expansion, then re-issue the key
    applyStimulus(FIPS_KEY);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy",       128'(busy),       128'd0);
    checkOutput("midrst_sched_done", 128'(sched_done), 128'd0);
    checkOutput("midrst_key_ready",  128'(key_ready),  128'd1);
    reset = 1'b0;
    applyStimulus(FIPS_KEY);
    waitDone(n);
    checkOutput("midrst_latency", 128'(n), 128'd10);
    readKey(4'd10, d);
    checkOutput("midrst_rk10", d, FIPS_RK10);

    // key_valid held high through an expansion; second key taken in DONE
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    computeModel(ka);
    a10 = exp_rk[10];
    @(negedge clk);
    rk_addr   = 4'd10;
    key_in    = ka;
    key_valid = 1'b1;
    @(negedge clk);
    key_in = kb;
    n = 0;
    while (!sched_done && n < 40) begin
      checkOutput($sformatf("hold_ready_c%0d", n), 128'(key_ready), 128'd0);
      @(negedge clk);
      n++;
    end
    checkOutput("hold_latency", 128'(n), 128'd10);
    @(negedge clk);
    checkOutput("hold_rk10_a",      rk_data,          a10);
    checkOutput("hold_sched_drop",  128'(sched_done), 128'd0);
    checkOutput("hold_second_busy", 128'(busy),       128'd1);
    key_valid = 1'b0;
    computeModel(kb);
    waitDone(n);
    checkOutput("hold_second_latency", 128'(n), 128'd10);
    readKey(4'd10, d);
    checkOutput("hold_rk10_b", d, exp_rk[10]);

    // Back-to-back from DONE: FIPS key, then the all-zero key
    applyStimulus(FIPS_KEY);
    waitDone(n);
    checkOutput("b2b_first_latency", 128'(n), 128'd10);
    computeModel(128'd0);
    applyStimulus(128'd0);
    checkOutput("b2b_sched_drop", 128'(sched_done), 128'd0);
    waitDone(n);
    checkOutput("b2b_latency", 128'(n), 128'd10);
    readKey(4'd1, d);
    checkOutput("zero_rk1_const", d, ZERO_RK1);
    readKey(4'd10, d);
    checkOutput("zero_rk10_const", d, ZERO_RK10);
    checkSchedule("zero");

    // Random keys against the model
    for (int k = 0; k < 5; k++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      computeModel(ka);
      applyStimulus(ka);
      waitDone(n);
      checkOutput($sformatf("rand%0d_latency", k), 128'(n), 128'd10);
      checkSchedule($sformatf("rand%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
